display_arbiter: RTL and testbench
==================================

# display_arbiter

Arbitrates the calculator's single signed 8-bit display path between three requesters: operand A entry, operand B entry and the ALU result. The block sits directly upstream of the output unit and drives its `EightBitNumber` input. It grants requesters round-robin and latches the granted value. Each grant is held on the display for a fixed minimum time so that every value stays readable.

## Interface

Parameters:
- `DIV`, default 50000: clock cycles per display tick (1 ms at 50 MHz). Must be ≥ 1.
- `HOLD_MS`, default 500: ticks a granted value is held before re-arbitration. Must be ≥ 1.

Ports:
- `clock`  in  1: single system clock; all logic is on its rising edge.
- `Reset`  in  1: synchronous, active-high; sampled on the rising edge of `clock`.
- `req`  in  3: level requests. `req[0]` = operand A, `req[1]` = operand B, `req[2]` = result. A requester holds its bit high until it sees `ack`.
- `data0`, `data1`, `data2`  in  8 each: two's-complement values of the requesters; sampled only at grant.
- `ack`  out  3: one-hot, one-cycle pulse marking the granted requester.
- `disp_value`  out  8: registered value fed to the output unit.
- `disp_src`  out  2: source of `disp_value`. 0 = none since reset, 1/2/3 = requester 0/1/2.
- `busy`  out  1: high while in HOLD.

## Operation

States: IDLE and HOLD.

Round-robin pointer `last` (2 bits):
- Reset value is 2, so requester 0 has the highest priority first.
- Search order is `last`+1, `last`+2, `last`+3, modulo 3.
- The first asserted `req` bit in that order wins.

IDLE:
- When any `req` bit is high at a clock edge, grant at that same edge:
  - `disp_value` ← dataN;
  - `disp_src` ← N+1;
  - `ack[N]` ← 1 for one cycle;
  - `last` ← N;
  - hold counter loaded;
  - tick counter cleared;
  - move to HOLD.
- With no requests, the state is unchanged and `disp_value`/`disp_src` keep the last granted value.

HOLD:
- The tick counter counts 0..`DIV`-1 and wraps. Each wrap decrements the hold counter.
- Expiry is the edge at which the last tick completes, i.e. exactly `HOLD_MS`×`DIV` cycles after the grant edge.
- At the expiry edge:
  - if any `req` bit is high, grant the next requester immediately (back-to-back, no IDLE cycle);
  - otherwise go to IDLE.
- Requests are ignored before expiry. `req` may change freely during HOLD.
- The current owner re-requesting is treated like any other requester and competes round-robin.

Data width: values pass through unmodified as 8-bit two's complement. No sign handling is done in this block.

## Timing

- Reset values: `ack`=000, `disp_value`=0x00, `disp_src`=0, `busy`=0, state IDLE, `last`=2, all counters 0.
- Reset asserted at any point, including mid-HOLD or on a grant edge, wins over every other event. All outputs take their reset values at that edge.
- Grant latency: `req` sampled high at edge E in IDLE gives `ack`, `disp_value` and `disp_src` valid after edge E. `ack` deasserts after E+1.
- `busy` rises after the grant edge and stays high for `HOLD_MS`×`DIV` cycles. On a back-to-back regrant, `busy` stays high continuously.
- A request arriving exactly on the expiry edge is eligible at that edge.
- A requester dropping `req` before grant is simply not served; no state is kept for it.
- Only one `ack` bit is ever high, and never two cycles in a row to the same requester unless a full hold has elapsed between them.

## Test plan

Bench settings: `DIV`=4, `HOLD_MS`=2, so one hold = 8 cycles.

1. Reset for 2 cycles, no requests → `ack`=0, `disp_value`=0x00, `disp_src`=0, `busy`=0 throughout.
2. `req`=010 with `data1`=0x85 (−123) → `ack`=010 for one cycle, `disp_value`=0x85, `disp_src`=2, `busy` high for 8 cycles. Then IDLE, and `disp_value` stays 0x85.
3. `req`=111 held from reset with `data0`=0x7F, `data1`=0x80, `data2`=0x00 → grants to 0, 1, 2, 0 at edges E, E+8, E+16, E+24, and `busy` never drops.
4. `req`=101 held constantly → grants alternate 0, 2, 0, 2. Requester 1 is never acked.
5. Grant of requester 0, then `Reset` pulsed 3 cycles into HOLD while `req`=100 →
   - all outputs return to reset values on the next edge;
   - after `Reset` drops, requester 2 is granted in IDLE with `last` at its reset value (2).
6. During requester 0's hold, `req[1]` rises exactly on the expiry edge → `ack`=010 on that edge with no IDLE cycle. A `req[1]` pulse dropped before expiry is never acked.

Source files
------------

// File: rtl/display_arbiter.sv
// Round-robin arbiter for the calculator's 8-bit display path; each grant is held
// for HOLD_MS display ticks of DIV clocks before the next requester is served.
module display_arbiter #(
    parameter int unsigned DIV     = 50000,
    parameter int unsigned HOLD_MS = 500
) (
    input  logic       clock,
    input  logic       Reset,
    input  logic [2:0] req,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    input  logic [7:0] data2,
    output logic [2:0] ack,
    output logic [7:0] disp_value,
    output logic [1:0] disp_src,
    output logic       busy
);

    localparam int unsigned TW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned HW = (HOLD_MS > 1) ? $clog2(HOLD_MS) : 1;

    typedef enum logic [0:0] {StIdle, StHold} state_t;

    state_t        r_state;
    logic [1:0]    r_last;
    logic [TW-1:0] r_tick;
    logic [HW-1:0] r_hold;
    logic [2:0]    r_ack;
    logic [7:0]    r_value;
    logic [1:0]    r_src;
    logic          r_busy;

    logic          w_any;
    logic          w_tick_wrap;
    logic          w_expire;
    logic          w_grant;
    logic [1:0]    w_idx;
    logic [7:0]    w_data;

    // First requester set among a, b, c (in that order); only meaningful when |r.
    function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] a,
                                        input logic [1:0] b, input logic [1:0] c);
        if (r[a]) begin
            return a;
        end else if (r[b]) begin
            return b;
        end
        return c;
    endfunction

    always_comb begin
        w_any       = |req;
        w_tick_wrap = (r_tick == TW'(DIV - 1));
        w_expire    = (r_state == StHold) && w_tick_wrap && (r_hold == '0);
        w_grant     = w_any && ((r_state == StIdle) || w_expire);
        case (r_last)
            2'd0:    w_idx = pick(req, 2'd1, 2'd2, 2'd0);
            2'd1:    w_idx = pick(req, 2'd2, 2'd0, 2'd1);
            default: w_idx = pick(req, 2'd0, 2'd1, 2'd2);
        endcase
        case (w_idx)
            2'd0:    w_data = data0;
            2'd1:    w_data = data1;
            default: w_data = data2;
        endcase
    end

    always_ff @(posedge clock) begin
        if (Reset) begin
            r_state <= StIdle;
            r_last  <= 2'd2;
            r_tick  <= '0;
            r_hold  <= '0;
            r_ack   <= 3'b000;
            r_value <= 8'h00;
            r_src   <= 2'd0;
            r_busy  <= 1'b0;
        end else begin
            r_ack <= 3'b000;
            if (w_grant) begin
                r_state <= StHold;
                r_last  <= w_idx;
                r_tick  <= '0;
                r_hold  <= HW'(HOLD_MS - 1);
                r_ack   <= 3'b001 << w_idx;
                r_value <= w_data;
                r_src   <= w_idx + 2'd1;
                r_busy  <= 1'b1;
            end else if (w_expire) begin
                r_state <= StIdle;
                r_tick  <= '0;
                r_busy  <= 1'b0;
            end else if (r_state == StHold) begin
                if (w_tick_wrap) begin
                    r_tick <= '0;
                    r_hold <= r_hold - 1'b1;
                end else begin
                    r_tick <= r_tick + 1'b1;
                end
            end
        end
    end

    assign ack        = r_ack;
    assign disp_value = r_value;
    assign disp_src   = r_src;
    assign busy       = r_busy;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed plus randomized bench for display_arbiter, checked against a
// remaining-cycles reference model of the round-robin hold behaviour.
module tb_display_arbiter;

    localparam int unsigned DIV     = 4;
    localparam int unsigned HOLD_MS = 2;
    localparam int          HOLD_CY = DIV * HOLD_MS;

    logic       clock = 1'b0;
    logic       Reset;
    logic [2:0] req;
    logic [7:0] data0, data1, data2;
    logic [2:0] ack;
    logic [7:0] disp_value;
    logic [1:0] disp_src;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [2:0] m_ack;
    logic [7:0] m_val;
    logic [1:0] m_src;
    logic       m_busy;
    int         m_last;
    int         m_rem;

    display_arbiter #(.DIV(DIV), .HOLD_MS(HOLD_MS)) dut (
        .clock      (clock),
        .Reset      (Reset),
        .req        (req),
        .data0      (data0),
        .data1      (data1),
        .data2      (data2),
        .ack        (ack),
        .disp_value (disp_value),
        .disp_src   (disp_src),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] dsel(input int n);
        if (n == 0) return data0;
        if (n == 1) return data1;
        return data2;
    endfunction

    task automatic model_edge();
        int idx;
        if (Reset) begin
            m_ack = 3'b000; m_val = 8'h00; m_src = 2'd0; m_last = 2; m_rem = 0;
        end else begin
            m_ack = 3'b000;
            if (m_rem > 1) begin
                m_rem--;
            end else if (req != 3'b000) begin
                idx = -1;
                for (int k = 1; k <= 3; k++) begin
                    if (idx < 0 && req[(m_last + k) % 3]) idx = (m_last + k) % 3;
                end
                m_val  = dsel(idx);
                m_src  = 2'(idx + 1);
                m_ack  = 3'(1 << idx);
                m_last = idx;
                m_rem  = HOLD_CY;
            end else begin
                m_rem = 0;
            end
        end
        m_busy = (m_rem > 0);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        chk("ack", 8'(ack), 8'(m_ack));
        chk("disp_value", disp_value, m_val);
        chk("disp_src", 8'(disp_src), 8'(m_src));
        chk("busy", 8'(busy), 8'(m_busy));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        Reset = 1'b1; req = 3'b000; data0 = 8'h00; data1 = 8'h00; data2 = 8'h00;
        // 1: reset, idle
        run(2);
        chk("reset_src", 8'(disp_src), 8'd0);

        // 2: single requester 1 with a negative value
        Reset = 1'b0; req = 3'b010; data1 = 8'h85;
        step();
        chk("t2_ack", 8'(ack), 8'(3'b010));
        req = 3'b000;
        run(10);
        chk("t2_keep", disp_value, 8'h85);
        chk("t2_idle", 8'(busy), 8'd0);

        // 3: all requesting, rotation 0,1,2,0
        Reset = 1'b1; step();
        Reset = 1'b0; req = 3'b111; data0 = 8'h7F; data1 = 8'h80; data2 = 8'h00;
        run(33);

        // 4: 0 and 2 alternate
        Reset = 1'b1; step();
        Reset = 1'b0; req = 3'b101;
        run(33);

        // 5: reset mid-hold, then requester 2 granted from reset priority
        Reset = 1'b1; step();
        Reset = 1'b0; req = 3'b001; data2 = 8'hC3;
        step();
        req = 3'b100;
        run(3);
        Reset = 1'b1; step();
        chk("t5_rst_busy", 8'(busy), 8'd0);
        Reset = 1'b0; step();
        chk("t5_regrant", 8'(ack), 8'(3'b100));
        req = 3'b000;
        run(10);

        // 6: pulse on req[1] dropped before expiry, then rising on the expiry edge
        Reset = 1'b1; step();
        Reset = 1'b0; req = 3'b001; data1 = 8'h11;
        step();
        req = 3'b010; run(2);
        req = 3'b000; run(HOLD_CY - 3);
        req = 3'b010; step();
        chk("t6_b2b_ack", 8'(ack), 8'(3'b010));
        chk("t6_b2b_busy", 8'(busy), 8'd1);
        req = 3'b000;
        run(10);

        // Randomized traffic
        Reset = 1'b1; step();
        Reset = 1'b0;
        for (int i = 0; i < 800; i++) begin
            Reset = ($urandom_range(0, 49) == 0);
            req   = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom);
            data0 = 8'($urandom); data1 = 8'($urandom); data2 = 8'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
